// File: rtl/divmod_arb_pkg.sv
// Shared types for the divmod_arb scheduler: FSM state encoding and the
// requester-count derivation used by the arbiter and its requester blocks.
package divmod_arb_pkg;

  localparam int WIDTH_LOG_DEF = 4;
  localparam int NREQ_LOG_DEF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GO   = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  function automatic int nreq_of(input int nreq_log);
    return 1 << nreq_log;
  endfunction

endpackage

// File: rtl/divmod_arb_if.sv
// Requester-side and divider-side signal bundle for divmod_arb.
// slave = the scheduler's view, master = requesters plus the attached divmod.
interface divmod_arb_if
  import divmod_arb_pkg::*;
#(
  parameter int WIDTH_LOG = WIDTH_LOG_DEF,
  parameter int NREQ_LOG  = NREQ_LOG_DEF
);
  localparam int WIDTH = 1 << WIDTH_LOG;
  localparam int NREQ  = nreq_of(NREQ_LOG);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] num_flat;
  logic [NREQ*WIDTH-1:0] den_flat;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      quot;
  logic [WIDTH-1:0]      rem;
  logic                  error;
  logic                  busy;
  logic                  dm_go;
  logic [WIDTH-1:0]      dm_num;
  logic [WIDTH-1:0]      dm_den;
  logic                  dm_ready;
  logic                  dm_error;
  logic [WIDTH-1:0]      dm_quot;
  logic [WIDTH-1:0]      dm_rem;

  modport slave (
    input  req, num_flat, den_flat, dm_ready, dm_error, dm_quot, dm_rem,
    output done, quot, rem, error, busy, dm_go, dm_num, dm_den
  );

  modport master (
    output req, num_flat, den_flat, dm_ready, dm_error, dm_quot, dm_rem,
    input  done, quot, rem, error, busy, dm_go, dm_num, dm_den
  );

endinterface

// File: rtl/divmod_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the slot after the last
// advanced winner; slot 0 has top priority out of reset.
module rr_arbiter
  import divmod_arb_pkg::*;
#(
  parameter int NREQ_LOG = NREQ_LOG_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [nreq_of(NREQ_LOG)-1:0]   req_i,
  input  logic                           advance_i,
  output logic [nreq_of(NREQ_LOG)-1:0]   grant_o
);
  localparam int NREQ = nreq_of(NREQ_LOG);

  logic [NREQ_LOG-1:0] ptr_q;
  logic [NREQ_LOG-1:0] ptr_d;
  logic [NREQ_LOG-1:0] cand_s;
  logic [NREQ_LOG-1:0] win_idx_s;
  logic                found_s;

  // Rotating priority scan; the index wraps naturally at NREQ_LOG bits.
  always_comb begin
    grant_o   = '0;
    cand_s    = ptr_q;
    win_idx_s = ptr_q;
    found_s   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = ptr_q + NREQ_LOG'(k);
      if (!found_s && req_i[cand_s]) begin
        found_s   = 1'b1;
        win_idx_s = cand_s;
      end else begin
        found_s   = found_s;
      end
    end
    if (found_s) begin
      grant_o[win_idx_s] = 1'b1;
    end else begin
      grant_o = '0;
    end
    if (advance_i && found_s) begin
      ptr_d = win_idx_s + NREQ_LOG'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/divmod_arb.sv
// Shares one iterative divmod among NREQ requesters, one division in flight.
// Option: DIVMOD_ARB_DIV0_BYPASS_EN answers zero divisors from IDLE without the divider.
module divmod_arb
  import divmod_arb_pkg::*;
#(
  parameter int WIDTH_LOG = WIDTH_LOG_DEF,
  parameter int NREQ_LOG  = NREQ_LOG_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  divmod_arb_if.slave  bus
);
  localparam int WIDTH = 1 << WIDTH_LOG;
  localparam int NREQ  = nreq_of(NREQ_LOG);

  state_e            state_q;
  state_e            state_d;
  logic [NREQ-1:0]   grant_q;
  logic [NREQ-1:0]   grant_d;
  logic [NREQ-1:0]   done_q;
  logic [NREQ-1:0]   done_d;
  logic [WIDTH-1:0]  quot_q;
  logic [WIDTH-1:0]  quot_d;
  logic [WIDTH-1:0]  rem_q;
  logic [WIDTH-1:0]  rem_d;
  logic              error_q;
  logic              error_d;
  logic [NREQ-1:0]   req_masked_s;
  logic [NREQ-1:0]   arb_grant_s;
  logic              advance_s;
  logic [WIDTH-1:0]  grant_num_s;
  logic [WIDTH-1:0]  grant_den_s;

  // A requester whose done is pulsing cannot win again in that same cycle.
  assign req_masked_s = bus.req & ~done_q;

  rr_arbiter #(
    .NREQ_LOG (NREQ_LOG)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_masked_s),
    .advance_i (advance_s),
    .grant_o   (arb_grant_s)
  );

  // AND-OR operand mux on the registered grant; all-zero grant gives zero operands.
  always_comb begin
    grant_num_s = '0;
    grant_den_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_num_s = grant_num_s | (bus.num_flat[i*WIDTH +: WIDTH] & {WIDTH{grant_q[i]}});
      grant_den_s = grant_den_s | (bus.den_flat[i*WIDTH +: WIDTH] & {WIDTH{grant_q[i]}});
    end
  end

`ifdef DIVMOD_ARB_DIV0_BYPASS_EN
  logic [WIDTH-1:0] win_den_s;

  // Divisor of the requester winning arbitration this cycle.
  always_comb begin
    win_den_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_den_s = win_den_s | (bus.den_flat[i*WIDTH +: WIDTH] & {WIDTH{arb_grant_s[i]}});
    end
  end
`endif

  // Next-state and result capture for the IDLE -> GO -> WAIT sequence.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    done_d    = '0;
    quot_d    = quot_q;
    rem_d     = rem_q;
    error_d   = error_q;
    advance_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((|req_masked_s) && bus.dm_ready) begin
          advance_s = 1'b1;
          grant_d   = arb_grant_s;
`ifdef DIVMOD_ARB_DIV0_BYPASS_EN
          if (win_den_s == '0) begin
            done_d  = arb_grant_s;
            quot_d  = '0;
            rem_d   = '0;
            error_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GO;
          end
`else
          state_d = ST_GO;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GO: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // dm_ready is stale during GO, so it is only trusted from here on.
        if (bus.dm_ready) begin
          state_d = ST_IDLE;
          done_d  = grant_q;
          if (bus.dm_error) begin
            quot_d  = '0;
            rem_d   = '0;
            error_d = 1'b1;
          end else begin
            quot_d  = bus.dm_quot;
            rem_d   = bus.dm_rem;
            error_d = 1'b0;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, grant and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      error_q <= error_d;
    end
  end

  assign bus.done   = done_q;
  assign bus.quot   = quot_q;
  assign bus.rem    = rem_q;
  assign bus.error  = error_q;
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.dm_go  = (state_q == ST_GO);
  assign bus.dm_num = grant_num_s;
  assign bus.dm_den = grant_den_s;

endmodule
